// File: rtl/execute_md.sv
`default_nettype none
// ============================================================================
//  Module      : execute_md
//  Description : Iterative RV32M-style multiply/divide execute unit.
//                Radix-2 shift-add multiply and restoring divide on operand
//                magnitudes, one bit per cycle, with sign fix-up at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_md #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_fwdRs1,
    input  logic [1:0]      i_fwdRs2,
    input  logic [XLEN-1:0] i_EXEC_rs1,
    input  logic [XLEN-1:0] i_EXEC_rs2,
    input  logic [XLEN-1:0] i_MEM_rd,
    input  logic [XLEN-1:0] i_WB_rd,
    input  logic [XLEN-1:0] i_rdDataSave,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;       // multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_q;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier / dividend, becomes product low / quotient
    logic            negq_q;    // negate product or quotient at the end
    logic            negr_q;    // negate remainder at the end
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0]   rs1_d, rs2_d, mag1_d, mag2_d;
    logic              sgn1_d, sgn2_d, div0_d, ovf_d;
    logic [XLEN:0]     mul_sum_d;
    logic [XLEN:0]     div_sh_d;
    logic              div_ge_d;
    logic [XLEN-1:0]   div_rem_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   quot_d, rem_d, res_d;

    // Operand forwarding select and accept-time sign/special-case decode
    always_comb begin
        case (i_fwdRs1)
            2'd0:    rs1_d = i_EXEC_rs1;
            2'd1:    rs1_d = i_MEM_rd;
            2'd2:    rs1_d = i_WB_rd;
            default: rs1_d = i_rdDataSave;
        endcase
        case (i_fwdRs2)
            2'd0:    rs2_d = i_EXEC_rs2;
            2'd1:    rs2_d = i_MEM_rd;
            2'd2:    rs2_d = i_WB_rd;
            default: rs2_d = i_rdDataSave;
        endcase
        // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM
        sgn1_d = rs1_d[XLEN-1] && (i_funct3 != 3'd3) && (i_funct3 != 3'd5) && (i_funct3 != 3'd7);
        sgn2_d = rs2_d[XLEN-1] && ((i_funct3 == 3'd0) || (i_funct3 == 3'd1) ||
                                   (i_funct3 == 3'd4) || (i_funct3 == 3'd6));
        mag1_d = sgn1_d ? (~rs1_d + 1'b1) : rs1_d;
        mag2_d = sgn2_d ? (~rs2_d + 1'b1) : rs2_d;
        div0_d = i_funct3[2] && (rs2_d == '0);
        ovf_d  = i_funct3[2] && !i_funct3[0] && (rs1_d == MIN_INT) && (rs2_d == '1);
    end

    // One iteration step of each datapath and the sign-corrected final result
    always_comb begin
        mul_sum_d = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        div_sh_d  = {hi_q, lo_q[XLEN-1]};
        div_ge_d  = (div_sh_d >= {1'b0, a_q});
        div_rem_d = div_ge_d ? XLEN'(div_sh_d - {1'b0, a_q}) : div_sh_d[XLEN-1:0];
        prod_d    = negq_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quot_d    = negq_q ? (~lo_q + 1'b1) : lo_q;
        rem_d     = negr_q ? (~hi_q + 1'b1) : hi_q;
        if (op_q[2])
            res_d = op_q[1] ? rem_d : quot_d;
        else if (op_q == 3'd0)
            res_d = prod_d[XLEN-1:0];
        else
            res_d = prod_d[2*XLEN-1:XLEN];
    end

    // Stall while iterating, and combinationally while a request is being accepted
    assign o_busy = !i_rst && ((state_q == S_MUL) || (state_q == S_DIV) ||
                               ((state_q == S_IDLE) && i_valid && !i_flush));
    assign o_done   = done_q;
    assign o_result = result_q;

    // Control FSM and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (i_flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_valid) begin
                            op_q <= i_funct3;
                            if (div0_d) begin
                                lo_q    <= '1;
                                hi_q    <= rs1_d;
                                negq_q  <= 1'b0;
                                negr_q  <= 1'b0;
                                state_q <= S_DONE;
                            end else if (ovf_d) begin
                                lo_q    <= MIN_INT;
                                hi_q    <= '0;
                                negq_q  <= 1'b0;
                                negr_q  <= 1'b0;
                                state_q <= S_DONE;
                            end else begin
                                a_q     <= mag2_d;
                                lo_q    <= mag1_d;
                                hi_q    <= '0;
                                negq_q  <= sgn1_d ^ sgn2_d;
                                negr_q  <= sgn1_d;
                                cnt_q   <= CNT_INIT;
                                state_q <= i_funct3[2] ? S_DIV : S_MUL;
                            end
                        end
                    end
                    S_MUL: begin
                        hi_q  <= mul_sum_d[XLEN:1];
                        lo_q  <= {mul_sum_d[0], lo_q[XLEN-1:1]};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1))
                            state_q <= S_DONE;
                    end
                    S_DIV: begin
                        hi_q  <= div_rem_d;
                        lo_q  <= {lo_q[XLEN-2:0], div_ge_d};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1))
                            state_q <= S_DONE;
                    end
                    S_DONE: begin
                        done_q   <= 1'b1;
                        result_q <= res_d;
                        state_q  <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_md
//  Description : Scoreboard testbench for execute_md (XLEN=32), directed
//                vectors with hand-computed results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_md;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  fwd1 = '0, fwd2 = '0;
    logic [31:0] exec1 = '0, exec2 = '0, mem_rd = '0, wb_rd = '0, save_rd = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    execute_md #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_funct3(funct3),
        .i_fwdRs1(fwd1), .i_fwdRs2(fwd2),
        .i_EXEC_rs1(exec1), .i_EXEC_rs2(exec2),
        .i_MEM_rd(mem_rd), .i_WB_rd(wb_rd), .i_rdDataSave(save_rd),
        .i_flush(flush), .o_busy(busy), .o_done(done), .o_result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no pulse", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Issue one op, push its expectation, wait (bounded) for the monitor to consume it
    task automatic run_op(input logic [2:0] f3, input logic [1:0] f1, input logic [1:0] f2,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] m,
                          input logic [31:0] w, input logic [31:0] s,
                          input logic [31:0] exp, input int lat);
        int seen;
        int k;
        int busy_hi;
        @(negedge clk);
        funct3 = f3; fwd1 = f1; fwd2 = f2;
        exec1 = e1; exec2 = e2; mem_rd = m; wb_rd = w; save_rd = s;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        // operands must already be latched; disturb every source
        fwd1 = 2'($urandom); fwd2 = 2'($urandom);
        exec1 = $urandom; exec2 = $urandom; mem_rd = $urandom; wb_rd = $urandom; save_rd = $urandom;
        sb_q.push_back('{res: exp, lat: lat, acc: cyc});
        seen = done_cnt;
        k = 0;
        busy_hi = 0;
        while (done_cnt == seen && k < 60) begin
            @(negedge clk);
            #1;
            if (done_cnt == seen && busy) busy_hi++;
            k++;
        end
        if (done_cnt == seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no o_done after %0d cycles expected one", k);
            void'(sb_q.pop_front());
        end
        chk("busy_cycles", 32'(busy_hi), 32'(lat - 1));
        last_res = exp;
    endtask

    initial begin
        int d_before;
        // reset state, with a request pending so o_busy gating is exercised
        valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        valid = 1'b0;
        rst = 1'b0;

        //      f3    f1    f2    exec1         exec2         mem   wb    save  expected      lat
        run_op(3'd0, 2'd0, 2'd0, 32'd7,        32'hFFFFFFFD, 0,    0,    0,    32'hFFFFFFEB, 33);
        run_op(3'd1, 2'd0, 2'd0, 32'h80000000, 32'h80000000, 0,    0,    0,    32'h40000000, 33);
        run_op(3'd3, 2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,    0,    0,    32'hFFFFFFFE, 33);
        run_op(3'd2, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h00000002, 0,    0,    0,    32'hFFFFFFFF, 33);
        run_op(3'd5, 2'd0, 2'd0, 32'd5,        32'd0,        0,    0,    0,    32'hFFFFFFFF, 1);
        run_op(3'd6, 2'd0, 2'd0, 32'd5,        32'd0,        0,    0,    0,    32'd5,        1);
        run_op(3'd4, 2'd0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 0,    0,    0,    32'h80000000, 1);
        run_op(3'd6, 2'd0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 0,    0,    0,    32'd0,        1);
        run_op(3'd4, 2'd0, 2'd0, 32'hFFFFFFF9, 32'd2,        0,    0,    0,    32'hFFFFFFFD, 33);
        run_op(3'd6, 2'd0, 2'd0, 32'hFFFFFFF9, 32'd2,        0,    0,    0,    32'hFFFFFFFF, 33);
        run_op(3'd7, 2'd0, 2'd0, 32'hFFFFFFF9, 32'd2,        0,    0,    0,    32'd1,        33);
        run_op(3'd4, 2'd0, 2'd0, 32'd7,        32'hFFFFFFFE, 0,    0,    0,    32'hFFFFFFFD, 33);
        run_op(3'd6, 2'd0, 2'd0, 32'd7,        32'hFFFFFFFE, 0,    0,    0,    32'd1,        33);
        run_op(3'd5, 2'd1, 2'd2, 32'd0,        32'd0,        100,  7,    0,    32'd14,       33);
        run_op(3'd5, 2'd3, 2'd0, 32'd0,        32'd5,        0,    0,    50,   32'd10,       33);

        // flush 10 cycles into a DIV: no pulse, stall drops, result held
        d_before = done_cnt;
        @(negedge clk);
        funct3 = 3'd4; fwd1 = 2'd0; fwd2 = 2'd0; exec1 = 32'd100; exec2 = 32'd7;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_result", result, last_res);
        run_op(3'd0, 2'd0, 2'd0, 32'd3, 32'd4, 0, 0, 0, 32'd12, 33);
        chk("flush_no_done", 32'(done_cnt - d_before), 32'd1);

        // reset mid-MUL clears outputs immediately
        @(negedge clk);
        funct3 = 3'd0; exec1 = 32'd5; exec2 = 32'd6;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd4, 2'd0, 2'd0, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 32'hFFFFFFFD, 33);

        repeat (40) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter XLEN, default 32, sets operand/result width; the block SHALL support any XLEN >= 8.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset:
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_rst  in  1  asynchronous active-high reset.
REQ-003 The block SHALL provide these remaining ports:
- i_valid  in  1  request to start an op; sampled only in IDLE.
- i_funct3  in  3  RV M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_fwdRs1, i_fwdRs2  in  2 each  operand source: 0 no-fwd, 1 MEM, 2 WB, 3 saved-rd.
- i_EXEC_rs1, i_EXEC_rs2  in  XLEN  register-file operands.
- i_MEM_rd, i_WB_rd, i_rdDataSave  in  XLEN  forwarded results.
- i_flush  in  1  abort current op.
- o_busy  out  1  pipeline stall request.
- o_done  out  1  one-cycle result-valid pulse.
- o_result  out  XLEN  registered result.

Function
REQ-004 Operand selection SHALL be per i_fwdRs1/i_fwdRs2 (0 EXEC_rs, 1 MEM_rd, 2 WB_rd, 3 rdDataSave) and latched only on the accept edge.
REQ-005 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-006 Accept: IDLE && i_valid && !i_flush; latch operands, i_funct3, and sign flags; go to MUL (funct3<4) or DIV (funct3>=4), loading iteration counter = XLEN.
REQ-007 Special-case accepts SHALL go directly to DONE:
- divisor 0: quotient all-ones, remainder = dividend.
- signed DIV/REM with dividend = min-int and divisor = -1: quotient = min-int, remainder = 0.
REQ-008 MUL/DIV SHALL process one bit per cycle on operand magnitudes (radix-2 shift-add; restoring divide); on counter reaching 0, go to DONE.
REQ-009 MUL SHALL return low XLEN bits of the 2*XLEN product; MULH SHALL return high bits signed*signed, MULHSU high bits signed*unsigned, MULHU high bits unsigned*unsigned.
REQ-010 Quotient SHALL be negated iff operand signs differ (signed ops); remainder SHALL take the dividend's sign.
REQ-011 DONE SHALL drive o_done=1 for exactly one cycle with o_result updated on the same edge; next state IDLE.
REQ-012 Latency, accept edge to o_done high: XLEN+1 cycles normally, 1 cycle for special cases.
REQ-013 o_busy SHALL be 1 in MUL and DIV, 1 in IDLE while i_valid=1 and i_flush=0, and 0 in DONE.
REQ-014 i_valid outside IDLE SHALL be ignored; there is no queuing.
REQ-015 i_flush SHALL force IDLE on the next edge from any state, suppress o_done, and leave o_result unchanged; flush SHALL take priority over i_valid.
REQ-016 o_result SHALL hold its value until the next DONE.

Reset
REQ-017 While i_rst=1: state IDLE, counter 0, o_done 0, o_busy 0, o_result 0, all operand registers 0.
REQ-018 Reset mid-op SHALL abort with no o_done; the first accept after deassertion SHALL behave as from power-up.

Verification (XLEN=32)
REQ-019 MUL, rs1=7, rs2=0xFFFFFFFD -> o_result 0xFFFFFFEB, o_done exactly 33 cycles after accept, o_busy high throughout.
REQ-020 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-021 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each with o_done 1 cycle after accept.
REQ-022 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1.
REQ-023 Forwarding: fwdRs1=1 with MEM_rd=100, fwdRs2=2 with WB_rd=7, EXEC inputs 0, DIVU -> 14; changing forward inputs after the accept edge does not affect the result.
REQ-024 Flush 10 cycles into a DIV -> no o_done, o_busy 0 next cycle, o_result unchanged; a new MUL 3*4 accepted on the following cycle -> 12. Reset asserted mid-MUL -> all outputs 0 immediately.
